// File: rtl/mux_4x1.sv
// Four-input word multiplexer with a combinational output and a
// registered, valid-qualified copy for pipelined consumers.
module mux_4x1 #(
    parameter int unsigned     WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    output logic [WIDTH-1:0] Y,
    input  logic [1:0]       S,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] Y_q,
    output logic             q_valid
);

    // Select one input word; an unknown select yields all-X in simulation.
    always_comb begin
        Y = 'x;
        case (S)
            2'b00:   Y = I0;
            2'b01:   Y = I1;
            2'b10:   Y = I2;
            2'b11:   Y = I3;
            default: Y = 'x;
        endcase
    end

    // Capture the selected word when enabled; reset wins over enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            Y_q     <= RESET_VAL;
            q_valid <= 1'b0;
        end else if (en) begin
            Y_q     <= Y;
            q_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_4x1.sv
// Directed testbench for mux_4x1: combinational select, registered
// capture, enable hold, reset override and unknown-select propagation.
module tb_mux_4x1;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        reset;
    logic        en;
    logic [1:0]  S;
    logic [31:0] I0, I1, I2, I3;
    logic [31:0] Y, Y_q;
    logic        q_valid;
    logic [7:0]  y8, yq8;
    logic        qv8;

    int checks = 0;
    int errors = 0;

    mux_4x1 dut (
        .Y(Y), .S(S), .I0(I0), .I1(I1), .I2(I2), .I3(I3),
        .clk(clk), .reset(reset), .en(en),
        .Y_q(Y_q), .q_valid(q_valid)
    );

    mux_4x1 #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
        .Y(y8), .S(S), .I0(I0[7:0]), .I1(I1[7:0]), .I2(I2[7:0]),
        .I3(I3[7:0]), .clk(clk), .reset(reset), .en(en),
        .Y_q(yq8), .q_valid(qv8)
    );

    // Clock only toggles once the registered tests begin.
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_comb_select();
        logic [31:0] exp_y [4];
        exp_y = '{32'h0000AAAA, 32'hAAAA0000, 32'h0000FFFF, 32'hFFFF0000};
        for (int i = 0; i < 4; i++) begin
            S = i[1:0];
            #1;
            checks++;
            if (Y !== exp_y[i]) begin
                errors++;
                $display("FAIL comb_sel S=%0d: got %h want %h", i, Y, exp_y[i]);
            end
        end
    endtask

    task automatic test_input_change();
        S  = 2'b10;
        I2 = 32'h12345678;
        #1;
        checks++;
        if (Y !== 32'h12345678) begin
            errors++;
            $display("FAIL i2_change: got %h want 12345678", Y);
        end
        I0 = 32'h11111111;
        I1 = 32'h22222222;
        I3 = 32'h33333333;
        #1;
        checks++;
        if (Y !== 32'h12345678) begin
            errors++;
            $display("FAIL other_inputs: got %h want 12345678", Y);
        end
        I0 = 32'h0000AAAA;
        I1 = 32'hAAAA0000;
        I2 = 32'h0000FFFF;
        I3 = 32'hFFFF0000;
        #1;
    endtask

    task automatic test_reset();
        clk_run = 1'b1;
        reset = 1'b1;
        en    = 1'b0;
        tick();
        reset = 1'b0;
        checks++;
        if (Y_q !== 32'h0 || q_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset: got %h/%b want 00000000/0", Y_q, q_valid);
        end
        checks++;
        if (yq8 !== 8'hA5 || qv8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_val8: got %h/%b want a5/0", yq8, qv8);
        end
        en = 1'b1;
        S  = 2'b11;
        tick();
        checks++;
        if (Y_q !== 32'hFFFF0000 || q_valid !== 1'b1) begin
            errors++;
            $display("FAIL capture: got %h/%b want ffff0000/1", Y_q, q_valid);
        end
        checks++;
        if (yq8 !== 8'h00 || qv8 !== 1'b1) begin
            errors++;
            $display("FAIL capture8: got %h/%b want 00/1", yq8, qv8);
        end
    endtask

    task automatic test_hold();
        en = 1'b0;
        S  = 2'b00;
        #1;
        checks++;
        if (Y !== 32'h0000AAAA) begin
            errors++;
            $display("FAIL hold_comb: got %h want 0000aaaa", Y);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (Y_q !== 32'hFFFF0000 || q_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold edge%0d: got %h/%b want ffff0000/1",
                         i, Y_q, q_valid);
            end
        end
    endtask

    task automatic test_reset_override();
        reset = 1'b1;
        en    = 1'b1;
        S     = 2'b01;
        tick();
        checks++;
        if (Y_q !== 32'h0 || q_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_over: got %h/%b want 00000000/0", Y_q, q_valid);
        end
        checks++;
        if (yq8 !== 8'hA5) begin
            errors++;
            $display("FAIL rst_over8: got %h want a5", yq8);
        end
        checks++;
        if (Y !== 32'hAAAA0000) begin
            errors++;
            $display("FAIL rst_comb: got %h want aaaa0000", Y);
        end
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  sel [5];
        logic [31:0] exp_q [5];
        sel   = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        exp_q = '{32'hDEADBEEF, 32'hAAAA0000, 32'h0000FFFF,
                  32'hFFFF0000, 32'hDEADBEEF};
        en = 1'b1;
        I0 = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            S = sel[i];
            tick();
            checks++;
            if (Y_q !== exp_q[i] || q_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b step%0d: got %h/%b want %h/1",
                         i, Y_q, q_valid, exp_q[i]);
            end
        end
        I0 = 32'h0000AAAA;
    endtask

    task automatic test_x_select();
        logic [31:0] exp_y;
        S  = 2'bx1;
        en = 1'b1;
        #1;
        // A two-state simulator resolves the X bit; expect the word it picks.
        if ($isunknown(S)) exp_y = 'x;
        else exp_y = S[1] ? I3 : I1;
        checks++;
        if (Y !== exp_y) begin
            errors++;
            $display("FAIL x_sel_comb: got %h want %h", Y, exp_y);
        end
        tick();
        checks++;
        if (Y_q !== exp_y) begin
            errors++;
            $display("FAIL x_sel_reg: got %h want %h", Y_q, exp_y);
        end
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        S     = 2'b00;
        I0    = 32'h0000AAAA;
        I1    = 32'hAAAA0000;
        I2    = 32'h0000FFFF;
        I3    = 32'hFFFF0000;
        test_comb_select();
        test_input_change();
        test_reset();
        test_hold();
        test_reset_override();
        test_back_to_back();
        test_x_select();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
